instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Parametrised instruction memory with a built-in program loader and a stallable fetch port.
//  - The loader streams words in over a valid/ready handshake. The write address auto-increments.
//  - The fetch port returns one instruction per cycle with 1-cycle latency.
//  - It sits between the boot/debug loader and the processor fetch stage, replacing the bare instruction RAM.
// PARAMETERS
//  DATA_WIDTH  32  instruction word width (bits)
//  ADDR_WIDTH  10  word-address width; depth = 2**ADDR_WIDTH words
//  LOAD_BASE   0   first word address written by each load burst
//  FWD_EN      1   1 = read-during-write to same address returns new data; 0 = returns old RAM data
// PORTS
//  CLK          in   1             system clock; all state updates on posedge
//  nRST         in   1             asynchronous reset, active low
//  load_start   in   1             start a load burst (sampled only in IDLE)
//  load_len     in   ADDR_WIDTH+1  burst length in words, sampled with load_start
//  load_data    in   DATA_WIDTH    word to write
//  load_valid   in   1             load_data valid
//  load_ready   out  1             loader accepts a word this cycle
//  load_busy    out  1             FSM in LOAD
//  load_done    out  1             1-cycle pulse: burst completed
//  load_err     out  1             1-cycle pulse: burst rejected (bad length)
//  fetch_req    in   1             read request
//  fetch_addr   in   ADDR_WIDTH    word address to read
//  fetch_stall  in   1             hold fetch outputs
//  instr        out  DATA_WIDTH    fetched instruction
//  instr_valid  out  1             instr holds a valid fetch result
// BEHAVIOUR
//  Reset (nRST=0, async):
//  - state=IDLE; load_ready, load_busy, load_done, load_err, instr_valid=0; instr=0.
//  - Write pointer=LOAD_BASE; word counter=0.
//  - RAM contents are NOT reset.
//  FSM states: IDLE, LOAD, DONE, ERR.
//  - IDLE: on load_start, if load_len==0 or load_len>2**ADDR_WIDTH go to ERR, else go to LOAD.
//    On entering LOAD: wptr<=LOAD_BASE, cnt<=load_len.
//  - LOAD: load_ready=load_busy=1. On load_valid&load_ready, write ram[wptr]<=load_data.
//    Each write increments wptr modulo 2**ADDR_WIDTH (wraps past the top) and decrements cnt.
//    If cnt==1 at that write, go to DONE.
//  - DONE: load_done=1 for exactly one cycle, then IDLE.
//  - ERR: load_err=1 for exactly one cycle, then IDLE. No RAM write occurs.
//  - load_start outside IDLE is ignored. load_valid with load_ready=0 is dropped (no write).
//  - load_ready is a registered function of state: 1 exactly while in LOAD.
//  Fetch (independent of the FSM; allowed in every state):
//  - fetch_stall=1: instr and instr_valid hold their values; the request is ignored.
//  - fetch_stall=0, fetch_req=1: next cycle instr=ram[fetch_addr], instr_valid=1. Latency 1, throughput 1/cycle.
//  - fetch_stall=0, fetch_req=0: next cycle instr_valid=0; instr holds.
//  - Same-cycle write and fetch to the same address with FWD_EN=1: instr=load_data.
//  - Same case with FWD_EN=0: instr=previous RAM word.
//  Reset mid-LOAD:
//  - Burst aborts; no load_done pulse; words already written stay in RAM.
//  - Next burst restarts at LOAD_BASE.
// TESTING
//  1 Reset: nRST=0 mid-cycle -> all outputs 0 immediately, with no clock edge required.
//  2 Burst: load_len=4, data 0x11,0x22,0x33,0x44 with valid gaps -> ram[0..3] written;
//    load_done pulses 1 cycle after the 4th accept; fetch 0..3 returns each word 1 cycle later.
//  3 Wrap: LOAD_BASE=1022 (ADDR_WIDTH=10), load_len=4 -> writes land at 1022, 1023, 0, 1.
//    load_len=0 or 1025 -> load_err pulse, RAM unchanged.
//  4 Forwarding: FWD_EN=1, write 0xDEADBEEF at addr 5 while fetch_addr=5 -> instr=0xDEADBEEF.
//    Same stimulus with FWD_EN=0 -> old word.
//  5 Stall: fetch addr 2, then fetch_stall=1 for 3 cycles while fetch_addr changes
//    -> instr/instr_valid frozen at ram[2], 1; release -> resumes.
//  6 Abort: nRST pulse after 2 of 4 words -> no load_done, ram[0..1] kept;
//    new burst of 1 word writes at LOAD_BASE.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction RAM with streaming program loader and stallable 1-cycle fetch port
module instr_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LOAD_BASE  = 0,
    parameter int FWD_EN     = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(LOAD_BASE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_load_ready;
    logic                  r_load_busy;
    logic                  r_load_done;
    logic                  r_load_err;
    logic [DATA_WIDTH-1:0] r_ram [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;

    logic w_wr_en;
    logic w_len_bad;
    logic w_fwd;

    // r_load_ready is high exactly while in LOAD, so it doubles as the write qualifier
    assign w_wr_en   = r_load_ready & load_valid;
    assign w_len_bad = (load_len == '0) || (load_len > MAX_LEN);
    assign w_fwd     = (FWD_EN != 0) && w_wr_en && (r_wptr == fetch_addr);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_wptr       <= BASE;
            r_cnt        <= '0;
            r_load_ready <= 1'b0;
            r_load_busy  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        if (w_len_bad) begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state      <= S_LOAD;
                            r_wptr       <= BASE;
                            r_cnt        <= load_len;
                            r_load_ready <= 1'b1;
                            r_load_busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_wr_en) begin
                        r_wptr <= r_wptr + PTR_ONE;
                        r_cnt  <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state      <= S_DONE;
                            r_load_done  <= 1'b1;
                            r_load_ready <= 1'b0;
                            r_load_busy  <= 1'b0;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_ram[r_wptr] <= load_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else if (!fetch_stall) begin
            r_instr_valid <= fetch_req;
            if (fetch_req) begin
                r_instr <= w_fwd ? load_data : r_ram[fetch_addr];
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign load_busy   = r_load_busy;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;

endmodule
